vm3_mux_ser: RTL and testbench

VM3_MUX_SER -- requirements
Module: vm3_mux_ser

---
 rtl/vm3_mux_ser.sv | 173 +++++++++++++++++
 tb/tb_vm3_mux_ser.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm3_mux_ser.sv
// Status-to-mux serializer: snapshots an 8-bit status word and shifts it out as
// four dibits into the board mux register, strobing on the last dibit.
module vm3_mux_ser #(
  parameter int unsigned REFRESH = 255,
  parameter bit          SYNC_EN = 1'b1
) (
  input  logic       MCLK,
  input  logic       nRST,
  input  logic       nDCLO_I,
  input  logic       nACLO_I,
  input  logic       nHALT_I,
  input  logic       nEVNT_I,
  input  logic [3:0] nIRQ_I,
  output logic [1:0] MXIN,
  output logic       MXSTB,
  output logic       BUSY,
  output logic       SENT
);

  localparam int unsigned WW  = 8;
  localparam int unsigned RCW = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SH0  = 3'd1;
  localparam logic [2:0] S_SH1  = 3'd2;
  localparam logic [2:0] S_SH2  = 3'd3;
  localparam logic [2:0] S_STB  = 3'd4;

  localparam logic [RCW-1:0] RC_TERM = RCW'(REFRESH - 32'd1);
  localparam logic [RCW-1:0] RC_MAX  = '1;

  logic [WW-1:0] raw;
  logic [WW-1:0] w;

  assign raw = {nDCLO_I, nACLO_I, nHALT_I, nEVNT_I, nIRQ_I};

  // Optional two-flop synchronizer; resets to the inactive (all-high) level.
  generate
    if (SYNC_EN) begin : g_sync
      logic [WW-1:0] s1;
      logic [WW-1:0] s2;
      always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
          s1 <= '1;
          s2 <= '1;
        end else begin
          s1 <= raw;
          s2 <= s1;
        end
      end
      assign w = s2;
    end else begin : g_nosync
      assign w = raw;
    end
  endgenerate

  logic [2:0]     state, state_next;
  logic [WW-1:0]  f, f_next;
  logic [WW-1:0]  l, l_next;
  logic [RCW-1:0] rc, rc_next;
  logic           p, p_next;
  logic           dclo_q;
  logic           start;
  logic           dclo_fall;
  logic [1:0]     mxin_next;
  logic           mxstb_next;
  logic           busy_next;
  logic           sent_next;

  assign start     = (w != l) || (rc == RC_TERM) || p;
  assign dclo_fall = dclo_q & ~w[WW-1];

  // State, snapshot, last-sent, refresh counter and registered outputs.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      state  <= S_IDLE;
      f      <= '1;
      l      <= '1;
      rc     <= '0;
      p      <= 1'b1;
      dclo_q <= 1'b1;
      MXIN   <= 2'b11;
      MXSTB  <= 1'b0;
      BUSY   <= 1'b0;
      SENT   <= 1'b0;
    end else begin
      state  <= state_next;
      f      <= f_next;
      l      <= l_next;
      rc     <= rc_next;
      p      <= p_next;
      dclo_q <= w[WW-1];
      MXIN   <= mxin_next;
      MXSTB  <= mxstb_next;
      BUSY   <= busy_next;
      SENT   <= sent_next;
    end
  end

  // Next state plus the output values that belong to that next state.
  always_comb begin
    state_next = state;
    f_next     = f;
    l_next     = l;
    rc_next    = rc;
    p_next     = p;
    mxin_next  = 2'b11;
    mxstb_next = 1'b0;
    busy_next  = 1'b0;
    sent_next  = 1'b0;

    case (state)
      S_IDLE: begin
        if (rc != RC_MAX) rc_next = rc + RCW'(1);
        if (start) begin
          state_next = S_SH0;
          f_next     = w;
        end
      end
      S_SH0, S_SH1, S_SH2: begin
        // A power-fail edge mid-frame restarts with the fresh word.
        if (dclo_fall) begin
          state_next = S_SH0;
          f_next     = w;
        end else if (state == S_SH0) begin
          state_next = S_SH1;
        end else if (state == S_SH1) begin
          state_next = S_SH2;
        end else begin
          state_next = S_STB;
        end
      end
      S_STB: begin
        l_next  = f;
        rc_next = '0;
        if (w != f) begin
          state_next = S_SH0;
          f_next     = w;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (state_next == S_SH0) p_next = 1'b0;

    case (state_next)
      S_SH0: begin
        mxin_next = f_next[7:6];
        busy_next = 1'b1;
      end
      S_SH1: begin
        mxin_next = f_next[5:4];
        busy_next = 1'b1;
      end
      S_SH2: begin
        mxin_next = f_next[3:2];
        busy_next = 1'b1;
      end
      S_STB: begin
        mxin_next  = f_next[1:0];
        mxstb_next = 1'b1;
        busy_next  = 1'b1;
        sent_next  = 1'b1;
      end
      default: begin
        mxin_next = 2'b11;
      end
    endcase
  end

endmodule

// File: tb/tb_vm3_mux_ser.sv
// Directed bench for vm3_mux_ser: instance a uses defaults, instance b uses
// REFRESH=4 without synchronizers; a receiver-register model watches both.
module tb_vm3_mux_ser;

  logic       MCLK = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] a_in = 8'hFF;
  logic [7:0] b_in = 8'hFF;
  logic [1:0] a_mxin, b_mxin;
  logic       a_mxstb, b_mxstb, a_busy, b_busy, a_sent, b_sent;

  int n_checks = 0;
  int n_pass   = 0;

  logic [5:0] sh_a, sh_b;
  logic [7:0] rx_a, rx_b;
  int zero_a = 0, zero_b = 0, viol_a = 0, viol_b = 0;

  always #5 MCLK = ~MCLK;

  vm3_mux_ser u_dut_a (
    .MCLK(MCLK), .nRST(nrst),
    .nDCLO_I(a_in[7]), .nACLO_I(a_in[6]), .nHALT_I(a_in[5]), .nEVNT_I(a_in[4]),
    .nIRQ_I(a_in[3:0]),
    .MXIN(a_mxin), .MXSTB(a_mxstb), .BUSY(a_busy), .SENT(a_sent)
  );

  vm3_mux_ser #(.REFRESH(4), .SYNC_EN(1'b0)) u_dut_b (
    .MCLK(MCLK), .nRST(nrst),
    .nDCLO_I(b_in[7]), .nACLO_I(b_in[6]), .nHALT_I(b_in[5]), .nEVNT_I(b_in[4]),
    .nIRQ_I(b_in[3:0]),
    .MXIN(b_mxin), .MXSTB(b_mxstb), .BUSY(b_busy), .SENT(b_sent)
  );

  // Board receiver: shift every dibit, latch the last four on the strobe.
  always @(negedge MCLK) begin
    sh_a <= {sh_a[3:0], a_mxin};
    sh_b <= {sh_b[3:0], b_mxin};
    if (a_mxstb === 1'b1) begin
      rx_a <= {sh_a, a_mxin};
      if (zero_a < 3) viol_a <= viol_a + 1;
      zero_a <= 0;
    end else begin
      zero_a <= zero_a + 1;
    end
    if (b_mxstb === 1'b1) begin
      rx_b <= {sh_b, b_mxin};
      if (zero_b < 3) viol_b <= viol_b + 1;
      zero_b <= 0;
    end else begin
      zero_b <= zero_b + 1;
    end
  end

  task automatic wait_busy(input bit sel_b, input logic lvl);
    int   n = 0;
    logic cur;
    @(negedge MCLK);
    cur = sel_b ? b_busy : a_busy;
    while (cur !== lvl && n < 600) begin
      @(negedge MCLK);
      cur = sel_b ? b_busy : a_busy;
      n++;
    end
    n_checks++;
    if (cur !== lvl) $display("FAIL wait_busy_%s: busy=%b expected %b within 600 cycles", sel_b ? "b" : "a", cur, lvl);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [7:0] dib;
    logic [3:0] stb, bsy, snt;
    int busy_cnt = 0, stb_cnt = 0;
    nrst = 1'b0;
    a_in = 8'hFF;
    b_in = 8'hFF;
    repeat (3) @(negedge MCLK);
    n_checks++;
    if ({a_mxin, a_mxstb, a_busy, a_sent} !== 5'b11000) $display("FAIL reset_out_a: got %b expected 11000", {a_mxin, a_mxstb, a_busy, a_sent});
    else n_pass++;
    n_checks++;
    if ({b_mxin, b_mxstb, b_busy, b_sent} !== 5'b11000) $display("FAIL reset_out_b: got %b expected 11000", {b_mxin, b_mxstb, b_busy, b_sent});
    else n_pass++;
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge MCLK);
      dib = {dib[5:0], a_mxin};
      stb = {stb[2:0], a_mxstb};
      bsy = {bsy[2:0], a_busy};
      snt = {snt[2:0], a_sent};
    end
    n_checks++;
    if (dib !== 8'hFF) $display("FAIL first_frame_dibits: got %h expected ff", dib); else n_pass++;
    n_checks++;
    if (stb !== 4'b0001) $display("FAIL first_frame_strobe: got %b expected 0001", stb); else n_pass++;
    n_checks++;
    if (bsy !== 4'b1111) $display("FAIL first_frame_busy: got %b expected 1111", bsy); else n_pass++;
    n_checks++;
    if (snt !== 4'b0001) $display("FAIL first_frame_sent: got %b expected 0001", snt); else n_pass++;
    // REFRESH-1 = 254 counts plus the RC=0 cycle: 255 idle cycles.
    for (int i = 0; i < 255; i++) begin
      @(negedge MCLK);
      if (a_busy !== 1'b0) busy_cnt++;
      if (a_mxstb !== 1'b0) stb_cnt++;
    end
    n_checks++;
    if (busy_cnt !== 0) $display("FAIL idle_busy_cycles: got %0d expected 0", busy_cnt); else n_pass++;
    n_checks++;
    if (stb_cnt !== 0) $display("FAIL idle_strobes: got %0d expected 0", stb_cnt); else n_pass++;
    @(negedge MCLK);
    n_checks++;
    if (a_busy !== 1'b1) $display("FAIL refresh_start: busy=%b expected 1", a_busy); else n_pass++;
    n_checks++;
    if (rx_a !== 8'hFF) $display("FAIL rx_after_reset_frame: got %h expected ff", rx_a); else n_pass++;
  endtask

  task automatic test_irq();
    logic [7:0] dib;
    logic [5:0] stb, bsy;
    wait_busy(1'b0, 1'b0);
    a_in = 8'hFE;
    for (int i = 0; i < 6; i++) begin
      @(negedge MCLK);
      dib = {dib[5:0], a_mxin};
      stb = {stb[4:0], a_mxstb};
      bsy = {bsy[4:0], a_busy};
    end
    n_checks++;
    if (bsy !== 6'b001111) $display("FAIL irq_busy_latency: got %b expected 001111", bsy); else n_pass++;
    n_checks++;
    if (dib !== 8'hFE) $display("FAIL irq_dibits: got %h expected fe", dib); else n_pass++;
    n_checks++;
    if (stb !== 6'b000001) $display("FAIL irq_strobe: got %b expected 000001", stb); else n_pass++;
    @(negedge MCLK);
    n_checks++;
    if (rx_a !== 8'hFE) $display("FAIL irq_rx: got %h expected fe", rx_a); else n_pass++;
    n_checks++;
    if (a_busy !== 1'b0) $display("FAIL irq_back_to_idle: busy=%b expected 0", a_busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] dib;
    logic [9:0]  stb, bsy;
    a_in = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge MCLK);
      dib = {dib[13:0], a_mxin};
      stb = {stb[8:0], a_mxstb};
      bsy = {bsy[8:0], a_busy};
      if (i == 3) a_in = 8'hEF;
    end
    n_checks++;
    if (bsy !== 10'h0FF) $display("FAIL b2b_busy: got %b expected 0011111111", bsy); else n_pass++;
    n_checks++;
    if (stb !== 10'h011) $display("FAIL b2b_strobe: got %b expected 0000010001", stb); else n_pass++;
    n_checks++;
    if (dib !== 16'hFFEF) $display("FAIL b2b_dibits: got %h expected ffef", dib); else n_pass++;
    @(negedge MCLK);
    n_checks++;
    if (rx_a !== 8'hEF) $display("FAIL b2b_rx: got %h expected ef", rx_a); else n_pass++;
    n_checks++;
    if (a_busy !== 1'b0) $display("FAIL b2b_idle: busy=%b expected 0", a_busy); else n_pass++;
  endtask

  task automatic test_refresh_period();
    logic [23:0] stb, bsy;
    int n = 0;
    @(negedge MCLK);
    while (b_mxstb !== 1'b1 && n < 20) begin
      @(negedge MCLK);
      n++;
    end
    n_checks++;
    if (b_mxstb !== 1'b1) $display("FAIL refresh_first_strobe: strobe=%b expected 1 within 20 cycles", b_mxstb);
    else n_pass++;
    for (int i = 0; i < 24; i++) begin
      @(negedge MCLK);
      stb = {stb[22:0], b_mxstb};
      bsy = {bsy[22:0], b_busy};
    end
    n_checks++;
    if (stb !== 24'h010101) $display("FAIL refresh_strobe_spacing: got %h expected 010101", stb); else n_pass++;
    n_checks++;
    if (bsy !== 24'h0F0F0F) $display("FAIL refresh_busy_pattern: got %h expected 0f0f0f", bsy); else n_pass++;
    @(negedge MCLK);
    n_checks++;
    if (rx_b !== 8'hFF) $display("FAIL refresh_rx: got %h expected ff", rx_b); else n_pass++;
  endtask

  task automatic test_dclo_abort();
    logic [17:0] dib;
    logic [8:0]  stb, bsy;
    wait_busy(1'b1, 1'b0);
    wait_busy(1'b1, 1'b1);
    dib = {16'h0000, b_mxin};
    stb = {8'h00, b_mxstb};
    bsy = {8'h00, b_busy};
    for (int i = 1; i < 9; i++) begin
      @(negedge MCLK);
      dib = {dib[15:0], b_mxin};
      stb = {stb[7:0], b_mxstb};
      bsy = {bsy[7:0], b_busy};
      if (i == 1) b_in = 8'h7F;
    end
    n_checks++;
    if (dib !== 18'h3DFFF) $display("FAIL dclo_dibits: got %h expected 3dfff", dib); else n_pass++;
    n_checks++;
    if (stb !== 9'h008) $display("FAIL dclo_strobe: got %b expected 000001000", stb); else n_pass++;
    n_checks++;
    if (bsy !== 9'h1F8) $display("FAIL dclo_busy: got %b expected 111111000", bsy); else n_pass++;
    n_checks++;
    if (rx_b !== 8'h7F) $display("FAIL dclo_rx: got %h expected 7f", rx_b); else n_pass++;
    b_in = 8'hFF;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] dib;
    logic [7:0]  stb, bsy;
    logic [4:0]  pre;
    int stb_cnt = 0, busy_cnt = 0;
    wait_busy(1'b0, 1'b0);
    a_in = 8'hFE;
    for (int i = 0; i < 5; i++) begin
      @(negedge MCLK);
      pre = {pre[3:0], a_busy};
    end
    n_checks++;
    if (pre !== 5'b00111) $display("FAIL midreset_reach_sh2: busy=%b expected 00111", pre); else n_pass++;
    nrst = 1'b0;
    #1;
    n_checks++;
    if ({a_mxin, a_mxstb, a_busy, a_sent} !== 5'b11000) $display("FAIL midreset_out: got %b expected 11000", {a_mxin, a_mxstb, a_busy, a_sent});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge MCLK);
      if (a_mxstb !== 1'b0) stb_cnt++;
      if (a_busy !== 1'b0) busy_cnt++;
    end
    n_checks++;
    if (stb_cnt + busy_cnt !== 0) $display("FAIL midreset_quiet: strobes+busy=%0d expected 0", stb_cnt + busy_cnt); else n_pass++;
    nrst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge MCLK);
      dib = {dib[13:0], a_mxin};
      stb = {stb[6:0], a_mxstb};
      bsy = {bsy[6:0], a_busy};
    end
    n_checks++;
    if (dib !== 16'hFFFE) $display("FAIL midreset_dibits: got %h expected fffe", dib); else n_pass++;
    n_checks++;
    if (stb !== 8'h11) $display("FAIL midreset_strobe: got %b expected 00010001", stb); else n_pass++;
    n_checks++;
    if (bsy !== 8'hFF) $display("FAIL midreset_busy: got %b expected 11111111", bsy); else n_pass++;
    @(negedge MCLK);
    n_checks++;
    if (rx_a !== 8'hFE) $display("FAIL midreset_rx: got %h expected fe", rx_a); else n_pass++;
    n_checks++;
    if (a_busy !== 1'b0) $display("FAIL midreset_idle: busy=%b expected 0", a_busy); else n_pass++;
  endtask

  task automatic test_strobe_spacing();
    n_checks++;
    if (viol_a !== 0) $display("FAIL strobe_gap_a: got %0d violations expected 0", viol_a); else n_pass++;
    n_checks++;
    if (viol_b !== 0) $display("FAIL strobe_gap_b: got %0d violations expected 0", viol_b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_irq();
    test_back_to_back();
    test_refresh_period();
    test_dclo_abort();
    test_reset_mid_frame();
    test_strobe_spacing();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
